// File: rtl/dial_zero_tracker.sv
// dial_zero_tracker: steps a circular dial (0..DIAL_MAX) one position per
// cycle for each accepted command, counting commands that finish on zero
// (land_count) and individual steps that arrive on zero (pass_count).
// Both counts saturate; overflow is sticky until rst or clr.
module dial_zero_tracker #(
    parameter int INPUT_WIDTH  = 10,
    parameter int OUTPUT_WIDTH = 16,
    parameter int DIAL_MAX     = 99,
    parameter int DIAL_INIT    = 50,
    parameter int DIAL_WIDTH   = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    valid,
    output logic                    ready,
    input  logic                    step_direction,
    input  logic [INPUT_WIDTH-1:0]  step_count,
    output logic [DIAL_WIDTH-1:0]   dial,
    output logic [OUTPUT_WIDTH-1:0] land_count,
    output logic [OUTPUT_WIDTH-1:0] pass_count,
    output logic                    overflow
);

    localparam logic [DIAL_WIDTH-1:0]  DMAX  = DIAL_WIDTH'(DIAL_MAX);
    localparam logic [DIAL_WIDTH-1:0]  DINIT = DIAL_WIDTH'(DIAL_INIT);
    localparam logic [INPUT_WIDTH-1:0] ONE   = INPUT_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [INPUT_WIDTH-1:0]  remaining;
    logic                    dir_q;
    logic [DIAL_WIDTH-1:0]   dial_next;
    logic                    accept;
    logic                    last_step;
    logic                    land_inc;
    logic                    pass_inc;
    logic                    land_full;
    logic                    pass_full;

    // State register: reset and clr both return to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: zero-step commands never leave IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && (step_count != '0)) state_nxt = RUN;
            RUN:  if (last_step)                    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: ready is held low during reset as well as during clr and RUN
    always_comb begin
        ready = rst && (state == IDLE) && !clr;
    end

    // Step and count-event decode
    always_comb begin
        accept    = valid && ready;
        last_step = (state == RUN) && (remaining == ONE);
        if (dir_q)
            dial_next = (dial == DMAX) ? '0 : dial + DIAL_WIDTH'(1);
        else
            dial_next = (dial == '0) ? DMAX : dial - DIAL_WIDTH'(1);
        pass_inc  = (state == RUN) && (dial_next == '0);
        land_inc  = (accept && (step_count == '0) && (dial == '0)) ||
                    (last_step && (dial_next == '0));
        land_full = (land_count == '1);
        pass_full = (pass_count == '1);
    end

    // Datapath: command capture, dial stepping, saturating counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dial       <= DINIT;
            remaining  <= '0;
            dir_q      <= 1'b0;
            land_count <= '0;
            pass_count <= '0;
            overflow   <= 1'b0;
        end else if (clr) begin
            dial       <= DINIT;
            remaining  <= '0;
            dir_q      <= 1'b0;
            land_count <= '0;
            pass_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                dir_q     <= step_direction;
                remaining <= step_count;
            end else if (state == RUN) begin
                dial      <= dial_next;
                remaining <= remaining - ONE;
            end
            if (land_inc) begin
                if (land_full) overflow   <= 1'b1;
                else           land_count <= land_count + OUTPUT_WIDTH'(1);
            end
            if (pass_inc) begin
                if (pass_full) overflow   <= 1'b1;
                else           pass_count <= pass_count + OUTPUT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dial_zero_tracker.sv
// Self-checking bench for dial_zero_tracker: directed vector table, corner
// sequences (clr/rst mid-RUN, saturation on a 2-bit counter instance) and
// random commands checked against an arithmetic model of the dial.
module tb_dial_zero_tracker;

    localparam int P = 100;   // dial positions with DIAL_MAX = 99

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Default instance
    logic        clr_d, valid_d, dir_d, ready_d, ovf_d;
    logic [9:0]  cnt_d;
    logic [6:0]  dial_d;
    logic [15:0] land_d, pass_d;

    // Narrow-counter instance for saturation
    logic        clr_s, valid_s, dir_s, ready_s, ovf_s;
    logic [9:0]  cnt_s;
    logic [6:0]  dial_s;
    logic [1:0]  land_s, pass_s;

    dial_zero_tracker u_dut (
        .clk(clk), .rst(rst), .clr(clr_d), .valid(valid_d), .ready(ready_d),
        .step_direction(dir_d), .step_count(cnt_d), .dial(dial_d),
        .land_count(land_d), .pass_count(pass_d), .overflow(ovf_d)
    );

    dial_zero_tracker #(.OUTPUT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .clr(clr_s), .valid(valid_s), .ready(ready_s),
        .step_direction(dir_s), .step_count(cnt_s), .dial(dial_s),
        .land_count(land_s), .pass_count(pass_s), .overflow(ovf_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: unbounded true counts, saturated only when compared
    int m_dial[2];
    int m_land[2];
    int m_pass[2];
    int m_max[2];

    function automatic void model_clr(input int s);
        m_dial[s] = 50;
        m_land[s] = 0;
        m_pass[s] = 0;
    endfunction

    function automatic void model_cmd(input int s, input bit up, input int n);
        int d, fin, hits, k0;
        d = m_dial[s];
        if (up) begin
            hits = (d + n) / P;
            fin  = (d + n) % P;
        end else begin
            k0   = (d == 0) ? P : d;
            hits = (n >= k0) ? ((n - k0) / P + 1) : 0;
            fin  = (((d - n) % P) + P) % P;
        end
        m_pass[s] += hits;
        if (fin == 0) m_land[s] += 1;
        m_dial[s] = fin;
    endfunction

    function automatic bit rdy(input int s);
        return (s == 0) ? ready_d : ready_s;
    endfunction

    task automatic drive(input int s, input bit v, input bit d, input int c);
        if (s == 0) begin valid_d = v; dir_d = d; cnt_d = 10'(c); end
        else        begin valid_s = v; dir_s = d; cnt_s = 10'(c); end
    endtask

    task automatic set_clr(input int s, input bit v);
        if (s == 0) clr_d = v; else clr_s = v;
    endtask

    task automatic check_state(input int s, input string tag);
        int el, ep;
        bit eo;
        el = (m_land[s] > m_max[s]) ? m_max[s] : m_land[s];
        ep = (m_pass[s] > m_max[s]) ? m_max[s] : m_pass[s];
        eo = (m_land[s] > m_max[s]) || (m_pass[s] > m_max[s]);
        if (s == 0) begin
            check({tag, ".dial"}, int'(dial_d), m_dial[s]);
            check({tag, ".land"}, int'(land_d), el);
            check({tag, ".pass"}, int'(pass_d), ep);
            check({tag, ".ovf"},  int'(ovf_d),  int'(eo));
        end else begin
            check({tag, ".dial"}, int'(dial_s), m_dial[s]);
            check({tag, ".land"}, int'(land_s), el);
            check({tag, ".pass"}, int'(pass_s), ep);
            check({tag, ".ovf"},  int'(ovf_s),  int'(eo));
        end
    endtask

    // Issue one command; valid is held high with junk while busy to show it is ignored.
    // Returns the number of cycles ready stayed low after acceptance.
    task automatic run_cmd(input int s, input bit up, input int n, output int low);
        int w;
        w = 0;
        while (!rdy(s) && w < 20) begin @(negedge clk); w++; end
        check("ready_before_cmd", int'(rdy(s)), 1);
        drive(s, 1'b1, up, n);
        @(posedge clk);
        @(negedge clk);
        low = 0;
        while (!rdy(s) && low < n + 10) begin
            drive(s, 1'b1, 1'($urandom), int'($urandom_range(0, 1023)));
            @(negedge clk);
            low++;
        end
        drive(s, 1'b0, 1'b0, 0);
        model_cmd(s, up, n);
    endtask

    task automatic do_clr(input int s);
        @(negedge clk);
        set_clr(s, 1'b1);
        #1;
        check("ready_during_clr", int'(rdy(s)), 0);
        @(posedge clk);
        @(negedge clk);
        set_clr(s, 1'b0);
        #1;
        model_clr(s);
        check_state(s, "after_clr");
        check("ready_after_clr", int'(rdy(s)), 1);
    endtask

    typedef struct {
        bit do_clr;
        bit up;
        int n;
        int e_dial;
        int e_land;
        int e_pass;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int low;
        tbl[0] = '{1'b1, 1'b0,  68, 82, 0, 1};
        tbl[1] = '{1'b1, 1'b1,  50,  0, 1, 1};
        tbl[2] = '{1'b0, 1'b1,   0,  0, 2, 1};
        tbl[3] = '{1'b1, 1'b0, 250,  0, 1, 3};
        tbl[4] = '{1'b0, 1'b1,   0,  0, 2, 3};
        tbl[5] = '{1'b0, 1'b0,   1, 99, 2, 3};
        tbl[6] = '{1'b0, 1'b1,   1,  0, 3, 4};
        tbl[7] = '{1'b0, 1'b0,   0,  0, 4, 4};
        m_max[0] = 65535;
        m_max[1] = 3;
        model_clr(0);
        model_clr(1);

        rst = 1'b0;
        clr_d = 0; valid_d = 0; dir_d = 0; cnt_d = '0;
        clr_s = 0; valid_s = 0; dir_s = 0; cnt_s = '0;
        #12;
        check("reset.ready", int'(ready_d), 0);
        check_state(0, "reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release.ready", int'(ready_d), 1);

        // Directed vectors with fixed expected values
        foreach (tbl[i]) begin
            if (tbl[i].do_clr) do_clr(0);
            run_cmd(0, tbl[i].up, tbl[i].n, low);
            check($sformatf("vec%0d.run_cycles", i), low, tbl[i].n);
            check($sformatf("vec%0d.dial", i), int'(dial_d), tbl[i].e_dial);
            check($sformatf("vec%0d.land", i), int'(land_d), tbl[i].e_land);
            check($sformatf("vec%0d.pass", i), int'(pass_d), tbl[i].e_pass);
            check($sformatf("vec%0d.ovf", i),  int'(ovf_d),  0);
        end

        // clr mid-RUN: first zero crossing already happened, must be discarded
        do_clr(0);
        drive(0, 1'b1, 1'b1, 200);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0);
        repeat (60) @(negedge clk);
        check("midrun.pass_before_clr", int'(pass_d), 1);
        do_clr(0);

        // Saturation on the 2-bit instance
        run_cmd(1, 1'b1, 50, low);
        check_state(1, "sat_prefix");
        for (int k = 0; k < 5; k++) begin
            run_cmd(1, 1'b1, 100, low);
            check($sformatf("sat%0d.run_cycles", k), low, 100);
            check_state(1, $sformatf("sat%0d", k));
        end
        check("sat.land_fixed", int'(land_s), 3);
        check("sat.pass_fixed", int'(pass_s), 3);
        check("sat.ovf_fixed",  int'(ovf_s),  1);
        do_clr(1);

        // rst mid-RUN with valid held high
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 200);
        @(posedge clk);
        repeat (70) @(negedge clk);
        check("rstmid.busy", int'(ready_d), 0);
        rst = 1'b0;
        #1;
        check("rstmid.ready", int'(ready_d), 0);
        model_clr(0);
        model_clr(1);
        check_state(0, "rstmid");
        drive(0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid.release_ready", int'(ready_d), 1);
        check_state(0, "rstmid_release");

        // Random commands against the model
        for (int r = 0; r < 40; r++) begin
            int n;
            bit up;
            if ($urandom_range(0, 9) == 0) begin
                do_clr(0);
            end else begin
                up = 1'($urandom);
                n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                                 : int'($urandom_range(0, 300));
                run_cmd(0, up, n, low);
                check($sformatf("rnd%0d.run_cycles", r), low, n);
                check_state(0, $sformatf("rnd%0d", r));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dial_zero_tracker.md
DIAL_ZERO_TRACKER -- requirements
Module: dial_zero_tracker

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 10, width of step_count.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 16, width of land_count and pass_count.
REQ-003 SHALL have parameter DIAL_MAX, default 99, highest dial position (inclusive); DIAL_MAX >= 1.
REQ-004 SHALL have parameter DIAL_INIT, default 50, dial position after reset or clr; DIAL_INIT <= DIAL_MAX.
REQ-005 SHALL have parameter DIAL_WIDTH, default 7, width of dial; must hold DIAL_MAX.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clr, input, 1, synchronous clear of counts, dial and any command in flight.
REQ-009 SHALL have port valid, input, 1, command present.
REQ-010 SHALL have port ready, output, 1, block can accept a command this cycle.
REQ-011 SHALL have port step_direction, input, 1, 1 = up (increment), 0 = down.
REQ-012 SHALL have port step_count, input, INPUT_WIDTH, number of unit steps in the command.
REQ-013 SHALL have port dial, output, DIAL_WIDTH, current dial position.
REQ-014 SHALL have port land_count, output, OUTPUT_WIDTH, commands that ended with dial == 0.
REQ-015 SHALL have port pass_count, output, OUTPUT_WIDTH, individual steps that moved the dial onto 0.
REQ-016 SHALL have port overflow, output, 1, sticky; set when either count saturates.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and RUN; ready = (state == IDLE) && !clr.
REQ-018 SHALL accept a command on a rising edge where valid && ready; step_direction and step_count are captured at that edge and never sampled again.
REQ-019 SHALL, on accepting step_count == 0, stay in IDLE, leave dial unchanged, increment land_count at that same edge if dial == 0, and leave pass_count unchanged.
REQ-020 SHALL, on accepting step_count == N > 0, enter RUN with remaining = N.
REQ-021 SHALL, in each RUN cycle, move dial by exactly one step and decrement remaining.
REQ-022 SHALL compute up steps as DIAL_MAX -> 0, else +1.
REQ-023 SHALL compute down steps as 0 -> DIAL_MAX, else -1.
REQ-024 SHALL increment pass_count at every RUN edge whose next dial value is 0.
REQ-025 SHALL, at the RUN edge where remaining == 1: increment land_count if the next dial value is 0, and return to IDLE.
REQ-026 SHALL take exactly N cycles in RUN for an N-step command; ready is high again on the cycle after the final step, giving a throughput of one command per N+1 cycles for N > 0.
REQ-027 SHALL ignore valid while in RUN; no command is queued.
REQ-028 SHALL saturate land_count and pass_count at all-ones, with no wrap-around.
REQ-029 SHALL set overflow on the edge at which an increment is requested while the counter is already all-ones; overflow is cleared only by rst or clr.
REQ-030 SHALL allow land_count and pass_count to increment on the same edge.
REQ-031 SHALL give clr priority over everything except rst: on a clr edge dial = DIAL_INIT, both counts = 0, overflow = 0, and state = IDLE.
REQ-032 SHALL, when clr is asserted during RUN, abort the command with no partial count update at that edge.
REQ-033 SHALL never accept a command on an edge where clr is high.

Reset
REQ-034 SHALL, while rst = 0, asynchronously force state = IDLE, dial = DIAL_INIT, land_count = 0, pass_count = 0, overflow = 0 and remaining = 0.
REQ-035 SHALL hold ready = 0 while rst = 0; ready = 1 from the first cycle after release, unless clr is high.
REQ-036 SHALL, when rst is asserted mid-RUN, discard the command in flight; no count reflects its partial steps.

Verification (defaults: DIAL_MAX = 99, DIAL_INIT = 50)
REQ-037 SHALL cover: down 68 from 50 -> ready low 68 cycles, dial = 82, pass_count = 1, land_count = 0.
REQ-038 SHALL cover: up 50 from 50 -> dial = 0, land_count = 1, pass_count = 1; then a 0-step command -> land_count = 2, pass_count = 1, ready never drops.
REQ-039 SHALL cover: down 250 from 50 -> dial = 0, pass_count = 3, land_count = 1, RUN exactly 250 cycles.
REQ-040 SHALL cover: OUTPUT_WIDTH = 2, five up-100 commands from dial 0 -> land_count = 3, pass_count = 3, overflow = 1; then clr -> all counts 0, overflow = 0, dial = 50.
REQ-041 SHALL cover: rst pulsed low mid-RUN of up 200 -> immediate dial = 50, counts 0, ready = 1 after release; valid held during RUN is ignored.
